tpu_host_seq: RTL and testbench

- Hardware bus master that drives the tpu single-cycle register/memory bus, replacing software or bench sequencing.
- On `start`, it writes the global enable register and polls the finish flag at a fixed interval, bounded by a timeout.
- It then reads back N result words from result memory and streams them out on a valid/ready port.
- Sits directly upstream of tpu, connected to its axi_req/axi_we/axi_addr/axi_wdata/axi_rdata ports.

---
 rtl/tpu_host_seq.sv | 163 ++++++++++++++++
 tb/tb_tpu_host_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_host_seq.sv
// Bus master that enables the tpu, polls its finish flag, then streams result words out.
// Optional macro TPU_HOST_SEQ_CLR_EN: write the enable register back to 0 before reporting done.
`timescale 1ns/1ps
module tpu_host_seq #(
    parameter logic [63:0] TPU_BASE   = 64'h4000_0000,
    parameter logic [15:0] STATUS_OFF = 16'h2E00,
    parameter int          POLL_GAP   = 10,
    parameter int          MAX_POLLS  = 100000,
    parameter int          NRES_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NRES_W-1:0] num_results,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [63:0]       res_data,
    output logic [NRES_W-1:0] res_idx,
    output logic              axi_req,
    output logic              axi_we,
    output logic [63:0]       axi_addr,
    output logic [63:0]       axi_wdata,
    input  logic [63:0]       axi_rdata
);
    localparam logic [63:0] ADDR_EN  = TPU_BASE + ({48'd0, STATUS_OFF} << 3);
    localparam logic [63:0] ADDR_FIN = TPU_BASE + (({48'd0, STATUS_OFF} + 64'd1) << 3);
    localparam int PCW = $clog2(MAX_POLLS + 2);
    localparam int GCW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_EN, S_POLL_RD, S_POLL_WT, S_GAP,
        S_RD_REQ, S_RD_WT, S_OUT, S_WR_CLR, S_DONE, S_ERR
    } state_t;

`ifdef TPU_HOST_SEQ_CLR_EN
    localparam state_t S_FINISH = S_WR_CLR;
`else
    localparam state_t S_FINISH = S_DONE;
`endif

    state_t            r_state;
    state_t            w_nextState;
    logic [NRES_W-1:0] r_numRes;
    logic [NRES_W-1:0] r_idx;
    logic [NRES_W-1:0] w_idxNext;
    logic [PCW-1:0]    r_pollCnt;
    logic [PCW-1:0]    w_pollNext;
    logic [GCW-1:0]    r_gapCnt;
    logic              r_done;
    logic              r_timeoutErr;
    logic [63:0]       r_resData;
    logic [NRES_W-1:0] r_resIdx;

    assign w_idxNext  = r_idx + NRES_W'(1);
    assign w_pollNext = r_pollCnt + PCW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nextState;
    end

    // Poll result is judged on the cycle after the read, when the tpu drives axi_rdata.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:    if (start) w_nextState = S_WR_EN;
            S_WR_EN:   w_nextState = S_POLL_RD;
            S_POLL_RD: w_nextState = S_POLL_WT;
            S_POLL_WT: begin
                if (axi_rdata[0])
                    w_nextState = (r_numRes == '0) ? S_FINISH : S_RD_REQ;
                else if (w_pollNext > PCW'(MAX_POLLS))
                    w_nextState = S_ERR;
                else
                    w_nextState = S_GAP;
            end
            S_GAP:     if (r_gapCnt == GCW'(POLL_GAP - 1)) w_nextState = S_POLL_RD;
            S_RD_REQ:  w_nextState = S_RD_WT;
            S_RD_WT:   w_nextState = S_OUT;
            S_OUT:     if (res_ready) w_nextState = (w_idxNext == r_numRes) ? S_FINISH : S_RD_REQ;
            S_WR_CLR:  w_nextState = S_DONE;
            S_DONE:    w_nextState = S_IDLE;
            S_ERR:     w_nextState = S_IDLE;
            default:   w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        axi_req   = 1'b0;
        axi_we    = 1'b0;
        axi_addr  = '0;
        axi_wdata = '0;
        case (r_state)
            S_WR_EN: begin
                axi_req   = 1'b1;
                axi_we    = 1'b1;
                axi_addr  = ADDR_EN;
                axi_wdata = 64'd1;
            end
            S_POLL_RD: begin
                axi_req  = 1'b1;
                axi_addr = ADDR_FIN;
            end
            S_RD_REQ: begin
                axi_req  = 1'b1;
                axi_addr = TPU_BASE + ({{(64-NRES_W){1'b0}}, r_idx} << 3);
            end
            S_WR_CLR: begin
                axi_req  = 1'b1;
                axi_we   = 1'b1;
                axi_addr = ADDR_EN;
            end
            default: ;
        endcase
    end

    assign busy        = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);
    assign res_valid   = (r_state == S_OUT);
    assign done        = r_done;
    assign timeout_err = r_timeoutErr;
    assign res_data    = r_resData;
    assign res_idx     = r_resIdx;

    // Flags are set on entry so they are already visible during the DONE/ERR cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_numRes     <= '0;
            r_idx        <= '0;
            r_pollCnt    <= '0;
            r_gapCnt     <= '0;
            r_done       <= 1'b0;
            r_timeoutErr <= 1'b0;
            r_resData    <= '0;
            r_resIdx     <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_numRes     <= num_results;
                    r_idx        <= '0;
                    r_pollCnt    <= '0;
                    r_done       <= 1'b0;
                    r_timeoutErr <= 1'b0;
                end
                S_POLL_WT: begin
                    r_gapCnt <= '0;
                    if (!axi_rdata[0]) r_pollCnt <= w_pollNext;
                end
                S_GAP:   r_gapCnt <= r_gapCnt + GCW'(1);
                S_RD_WT: begin
                    r_resData <= axi_rdata;
                    r_resIdx  <= r_idx;
                end
                S_OUT:   if (res_ready) r_idx <= w_idxNext;
                default: ;
            endcase
            if (w_nextState == S_DONE) r_done <= 1'b1;
            if (w_nextState == S_ERR)  r_timeoutErr <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tpu_host_seq.sv
// Self-checking bench for tpu_host_seq: a behavioural tpu bus model, an access log and a
// result scoreboard, driven by a linear sequence of directed and randomized cases.
`timescale 1ns/1ps
module tb_tpu_host_seq;
    localparam int          NRES_W   = 16;
    localparam int          GAP      = 10;
    localparam int          MAXP     = 50;
    localparam logic [63:0] BASE     = 64'h4000_0000;
    localparam logic [63:0] ADDR_EN  = 64'h4001_7000;
    localparam logic [63:0] ADDR_FIN = 64'h4001_7008;
`ifdef TPU_HOST_SEQ_CLR_EN
    localparam int CLR_WR = 1;
`else
    localparam int CLR_WR = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              resReady = 1'b1;
    logic [NRES_W-1:0] numResults = '0;
    logic              busy, done, timeoutErr, resValid;
    logic [63:0]       resData;
    logic [NRES_W-1:0] resIdx;
    logic              axiReq, axiWe;
    logic [63:0]       axiAddr, axiWdata;
    logic [63:0]       axiRdata = '0;

    typedef struct { int cyc; logic we; logic [63:0] addr; logic [63:0] data; } acc_t;
    typedef struct { logic [NRES_W-1:0] idx; logic [63:0] data; } res_t;
    acc_t accLog[$];
    res_t rxQ[$];
    acc_t monAcc;
    res_t monRes;

    logic [63:0] resMem [0:15];
    int  cyc = 0;
    int  enCyc = 0;
    int  finDelay = 1000;
    bit  stuck = 1'b0;
    bit  enReg = 1'b0;
    int  assertCount = 0;
    int  failCount = 0;
    int  busIdleErr = 0;
    int  stableErr = 0;
    int  reqInOutErr = 0;
    bit  prevValid = 1'b0;
    bit  prevReady = 1'b0;
    logic [63:0]       prevData = '0;
    logic [NRES_W-1:0] prevIdx = '0;

    tpu_host_seq #(
        .TPU_BASE(BASE), .STATUS_OFF(16'h2E00), .POLL_GAP(GAP), .MAX_POLLS(MAXP), .NRES_W(NRES_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_results(numResults),
        .busy(busy), .done(done), .timeout_err(timeoutErr),
        .res_valid(resValid), .res_ready(resReady), .res_data(resData), .res_idx(resIdx),
        .axi_req(axiReq), .axi_we(axiWe), .axi_addr(axiAddr), .axi_wdata(axiWdata),
        .axi_rdata(axiRdata)
    );

    always #5 clk = ~clk;

    // The tpu finish flag reads 1 once finDelay cycles have passed since the enable write;
    // the upper bits of the finish word are random so that only bit0 may matter.
    function automatic logic [63:0] readWord(input logic [63:0] a);
        logic [63:0] w;
        w = {$urandom, $urandom};
        if (a == ADDR_FIN)
            w[0] = enReg && !stuck && (cyc >= enCyc + finDelay);
        else if (a >= BASE && a < BASE + 64'd128 && a[2:0] == 3'd0)
            w = resMem[int'((a - BASE) >> 3)];
        return w;
    endfunction

    // Single-cycle bus model: read data is presented during the cycle after the request.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (axiReq && axiWe && axiAddr == ADDR_EN) begin
            enReg <= axiWdata[0];
            if (axiWdata[0]) enCyc <= cyc;
        end
        if (axiReq && !axiWe) axiRdata <= readWord(axiAddr);
        else                  axiRdata <= {$urandom, $urandom} & ~64'd1;
    end

    // Mid-cycle observer: logs bus accesses and handshakes, flags bus and stream rule breaks.
    always @(negedge clk) begin
        if (axiReq) begin
            monAcc.cyc = cyc; monAcc.we = axiWe; monAcc.addr = axiAddr; monAcc.data = axiWdata;
            accLog.push_back(monAcc);
        end else if (axiWe || axiAddr != 64'd0 || axiWdata != 64'd0) begin
            busIdleErr++;
        end
        if (resValid && resReady) begin
            monRes.idx = resIdx; monRes.data = resData;
            rxQ.push_back(monRes);
        end
        if (resValid && axiReq) reqInOutErr++;
        if (prevValid && !prevReady && (!resValid || resData !== prevData || resIdx !== prevIdx))
            stableErr++;
        prevValid = resValid; prevReady = resReady; prevData = resData; prevIdx = resIdx;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NRES_W-1:0] n);
        @(posedge clk); #1;
        start = 1'b1; numResults = n;
        @(posedge clk); #1;
        start = 1'b0; numResults = NRES_W'($urandom);
    endtask

    task automatic beginCase(input int d, input bit stk);
        accLog.delete();
        rxQ.delete();
        finDelay = d;
        stuck = stk;
        for (int i = 0; i < 16; i++) resMem[i] = {$urandom, $urandom};
    endtask

    task automatic waitDone(input int budget);
        int k;
        k = 0;
        while (!((done || timeoutErr) && !busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput("finishWithinBudget", 64'(k < budget), 64'd1);
    endtask

    // Spec-level poll count: polls start 1 cycle after the enable write, are POLL_GAP+2 apart,
    // and stop at the first one that sees the flag, or after MAX_POLLS+1 misses.
    function automatic int expPollCount(input int wrCyc, input int d, input bit stk);
        int c, p;
        if (stk) return MAXP + 1;
        c = wrCyc + 1;
        p = 1;
        while (c < wrCyc + d && p <= MAXP) begin
            c += GAP + 2;
            p++;
        end
        return p;
    endfunction

    task automatic checkRun(input int n, input bit timedOut);
        int polls, badGap, lastPoll, firstPoll, rdCount, badRdAddr, clrWrites, extraWrites, expPolls;
        polls = 0; badGap = 0; lastPoll = -1; firstPoll = -1; rdCount = 0;
        badRdAddr = 0; clrWrites = 0; extraWrites = 0; expPolls = -1;
        checkOutput("logNonEmpty", 64'(accLog.size() > 0), 64'd1);
        if (accLog.size() > 0) begin
            checkOutput("enWrAddr", accLog[0].addr, ADDR_EN);
            checkOutput("enWrData", accLog[0].data, 64'd1);
            checkOutput("enWrWe", 64'(accLog[0].we), 64'd1);
            expPolls = expPollCount(accLog[0].cyc, finDelay, stuck);
        end
        for (int i = 1; i < accLog.size(); i++) begin
            if (!accLog[i].we && accLog[i].addr == ADDR_FIN) begin
                if (polls == 0) firstPoll = accLog[i].cyc - accLog[0].cyc;
                else if (accLog[i].cyc - lastPoll != GAP + 2) badGap++;
                lastPoll = accLog[i].cyc;
                polls++;
            end else if (!accLog[i].we) begin
                if (accLog[i].addr != BASE + 64'(rdCount) * 64'd8) badRdAddr++;
                rdCount++;
            end else if (accLog[i].addr == ADDR_EN && accLog[i].data == 64'd0 && i == accLog.size() - 1) begin
                clrWrites++;
            end else begin
                extraWrites++;
            end
        end
        checkOutput("firstPollLatency", 64'(firstPoll), 64'd1);
        checkOutput("pollCount", 64'(polls), 64'(expPolls));
        checkOutput("pollSpacing", 64'(badGap), 64'd0);
        checkOutput("resultReads", 64'(rdCount), timedOut ? 64'd0 : 64'(n));
        checkOutput("resultReadAddr", 64'(badRdAddr), 64'd0);
        checkOutput("enClearWrite", 64'(clrWrites), timedOut ? 64'd0 : 64'(CLR_WR));
        checkOutput("unexpectedWrite", 64'(extraWrites), 64'd0);
        checkOutput("rxCount", 64'(rxQ.size()), timedOut ? 64'd0 : 64'(n));
        for (int i = 0; i < rxQ.size() && i < 16; i++) begin
            checkOutput("rxIdx", 64'(rxQ[i].idx), 64'(i));
            checkOutput("rxData", rxQ[i].data, resMem[i]);
        end
        checkOutput("doneFlag", 64'(done), timedOut ? 64'd0 : 64'd1);
        checkOutput("timeoutFlag", 64'(timeoutErr), timedOut ? 64'd1 : 64'd0);
        checkOutput("busyAtEnd", 64'(busy), 64'd0);
        checkOutput("busIdleZero", 64'(busIdleErr), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstDone", 64'(done), 64'd0);
        checkOutput("rstTimeout", 64'(timeoutErr), 64'd0);
        checkOutput("rstValid", 64'(resValid), 64'd0);
        checkOutput("rstData", resData, 64'd0);
        checkOutput("rstIdx", 64'(resIdx), 64'd0);
        checkOutput("rstAddr", axiAddr, 64'd0);
        accLog.delete();
        repeat (10) @(negedge clk);
        checkOutput("idleNoReq", 64'(accLog.size()), 64'd0);

        $display("[TB] case: two results after a long tpu run");
        beginCase(int'($urandom_range(450, 550)), 1'b0);
        resMem[0] = 64'hA5;
        resMem[1] = 64'h5A;
        applyStimulus(2);
        checkOutput("busyAfterStart", 64'(busy), 64'd1);
        waitDone(2000);
        checkRun(2, 1'b0);

        $display("[TB] case: consumer stalls the first result");
        beginCase(int'($urandom_range(30, 80)), 1'b0);
        resReady = 1'b0;
        applyStimulus(3);
        k = 0;
        while (!resValid && k < 2000) begin
            @(negedge clk);
            k++;
        end
        checkOutput("validSeen", 64'(k < 2000), 64'd1);
        repeat (7) @(posedge clk);
        #1;
        checkOutput("validHeldDuringStall", 64'(resValid), 64'd1);
        checkOutput("idxHeldDuringStall", 64'(resIdx), 64'd0);
        checkOutput("dataHeldDuringStall", resData, resMem[0]);
        resReady = 1'b1;
        waitDone(2000);
        checkRun(3, 1'b0);
        checkOutput("stableDuringStall", 64'(stableErr), 64'd0);
        checkOutput("noReqDuringOut", 64'(reqInOutErr), 64'd0);

        $display("[TB] case: finish already set on the first poll");
        beginCase(1, 1'b0);
        applyStimulus(1);
        waitDone(500);
        checkRun(1, 1'b0);

        $display("[TB] case: finish stuck low until timeout");
        beginCase(0, 1'b1);
        applyStimulus(4);
        waitDone((MAXP + 2) * (GAP + 2) + 100);
        checkRun(4, 1'b1);

        $display("[TB] case: zero results with a stray start during polling");
        beginCase(int'($urandom_range(150, 250)), 1'b0);
        applyStimulus(0);
        repeat (40) @(posedge clk);
        applyStimulus(5);
        checkOutput("busyAfterStrayStart", 64'(busy), 64'd1);
        waitDone(2000);
        checkRun(0, 1'b0);

        $display("[TB] case: reset during the poll gap, then clean restart");
        beginCase(0, 1'b1);
        applyStimulus(2);
        k = 0;
        while (accLog.size() < 2 && k < 500) begin
            @(negedge clk);
            k++;
        end
        checkOutput("firstPollSeen", 64'(k < 500), 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abortBusy", 64'(busy), 64'd0);
        checkOutput("abortReq", 64'(axiReq), 64'd0);
        checkOutput("abortDone", 64'(done), 64'd0);
        checkOutput("abortTimeout", 64'(timeoutErr), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        beginCase(int'($urandom_range(60, 120)), 1'b0);
        applyStimulus(2);
        waitDone(2000);
        checkRun(2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
